wb_pmem_responder: RTL and testbench
====================================

Name: wb_pmem_responder

Overview:
- Wishbone slave that terminates the physical-memory bus driven by the L2/evict path.
- Backed by an internal line-wide storage array with programmable access latency.
- Serves as the synthesizable physical-memory model behind the cache hierarchy for simulation and FPGA bring-up.
- Accepts one 128-bit line request at a time, applies byte-masked writes and returns read data with a single-cycle ACK.

Parameters:
- DEPTH, 4096, number of 128-bit lines stored; equals the full 12-bit line address space.
- LATENCY, 4, cycles from request acceptance to ACK; legal range 1..15.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- CYC  in  1  bus cycle active.
- STB  in  1  request strobe.
- WE  in  1  1 = write, 0 = read.
- ADR  in  12  line address.
- SEL  in  16  byte enables for writes; bit i covers DAT_M[8i+7:8i].
- DAT_M  in  128  write data from master.
- DAT_S  out  128  read data to master.
- ACK  out  1  request complete.
- STALL  out  1  slave busy; request not accepted.
- RTY  out  1  retry/error termination (see Optional Feature).

Behaviour:
- Reset (RST_N low, asynchronous): state = IDLE, ACK = 0, RTY = 0, STALL = 0, DAT_S = 0, counter = 0. Storage array is not reset. Deassertion takes effect on the next CLK edge.
- Acceptance: occurs on the rising edge where CYC & STB & !STALL. At that edge the block latches ADR, WE, SEL and DAT_M; master inputs may change afterwards.
- STALL = 1 in every state except IDLE. It is a combinational function of state only.
- States:
  - IDLE: on acceptance, load counter = LATENCY-1 and go to WAIT if LATENCY > 1; otherwise go straight to RESP.
  - WAIT: decrement counter each cycle; when counter reaches 1, go to RESP next.
  - RESP: ACK = 1 for exactly this cycle, then return to IDLE.
- Timing: acceptance at edge T gives ACK high in the cycle following edge T+LATENCY-1, so ACK is observed at edge T+LATENCY. A new request can be accepted no earlier than edge T+LATENCY+1. Throughput is one request per LATENCY+1 cycles.
- Writes: committed to the array in the RESP cycle. Only bytes with SEL=1 are updated; SEL = 0 commits nothing but still ACKs. DAT_S is unchanged by writes.
- Reads: DAT_S is registered with the array line at the latched address and is valid in the RESP cycle. It holds that value until the next read ACK.
- Read-after-write: a read of the same line accepted after a write's ACK returns the written data.
- CYC deasserted in WAIT or RESP: abort, return to IDLE next edge, no ACK. A pending write is discarded; an abort in RESP suppresses ACK and the commit. STB low while CYC high has no effect on an in-flight request.
- Addressing: with DEPTH < 4096, the array index is ADR modulo DEPTH (low log2(DEPTH) bits).
- ACK and RTY are never high in the same cycle.

Optional Feature:
- Macro: WB_PMEM_RANGE_CHECK_EN.
- With the macro defined: a request whose latched ADR >= DEPTH completes with RTY = 1 (one cycle, in place of ACK) in the RESP cycle. No array access is made and DAT_S holds its previous value.
- Without the macro: RTY is tied to 0 and out-of-range addresses wrap modulo DEPTH as above.

Test Plan:
- Reset: hold RST_N low mid-WAIT of a write to ADR 0x010 -> ACK, STALL, RTY, DAT_S all 0 immediately. No ACK follows. A later read of 0x010 does not return the aborted data.
- Write then read, LATENCY=4: write ADR 0x123, SEL 0xFFFF, DAT_M 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, accepted at edge T -> ACK observed at edge T+4, STALL high T+1..T+4. A read of 0x123 then returns the same data with ACK 4 edges after its acceptance.
- Byte mask: line 0x040 preloaded with all 0xAA, then write SEL 0x0003, DAT_M all 0x55 -> reading 0x040 returns 0xAAAA...AA5555 (only bytes 0 and 1 changed).
- Back-to-back stall, LATENCY=1: master holds CYC/STB high for two reads -> the second request is accepted only at edge T+2, ACKs are seen at edges T+1 and T+3, and STALL is high in between.
- Abort: CYC dropped two cycles after accepting a write to 0x200 with DAT_M all 0xFF -> no ACK, back in IDLE next edge, and a read of 0x200 returns the old contents.
- Range, DEPTH=256: with WB_PMEM_RANGE_CHECK_EN, a read of ADR 0x300 -> RTY for one cycle, ACK stays 0. Without the macro, a write to 0x300 followed by a read of 0x000 returns the written data.

Source files
------------

// File: rtl/wb_pmem_responder.sv
// Wishbone physical-memory responder: 128-bit line array, programmable ACK latency.
// Optional WB_PMEM_RANGE_CHECK_EN: out-of-range line addresses terminate with RTY.
module wb_pmem_responder #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CYC,
  input  logic         STB,
  input  logic         WE,
  input  logic [11:0]  ADR,
  input  logic [15:0]  SEL,
  input  logic [127:0] DAT_M,
  output logic [127:0] DAT_S,
  output logic         ACK,
  output logic         STALL,
  output logic         RTY
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [12:0] DEPTH_L = 13'(DEPTH);
`ifdef WB_PMEM_RANGE_CHECK_EN
  localparam logic RANGE_CHK = 1'b1;
`else
  localparam logic RANGE_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic           we_q;
  logic [11:0]    adr_q;
  logic [15:0]    sel_q;
  logic [127:0]   dat_q;
  logic           accept, load_rd, commit, resp_ok;
  logic [AW-1:0]  rd_idx;

  logic [127:0] mem [DEPTH];

  // Without range checking every address is legal and simply wraps modulo DEPTH.
  function automatic logic in_rng(input logic [11:0] a);
    return !RANGE_CHK || ({1'b0, a} < DEPTH_L);
  endfunction

  assign accept = CYC & STB & (state == S_IDLE);
  // Entering RESP straight from IDLE (LATENCY=1) happens on the accept edge itself.
  assign rd_idx = (state == S_IDLE) ? ADR[AW-1:0] : adr_q[AW-1:0];
  assign resp_ok = (state == S_RESP) & CYC;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_rd   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY > 1) begin
            cnt_nxt   = 4'(LATENCY - 1);
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_RESP;
            load_rd   = !WE && in_rng(ADR);
          end
        end
      end
      S_WAIT: begin
        if (!CYC) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == 4'd1) begin
          state_nxt = S_RESP;
          cnt_nxt   = '0;
          load_rd   = !we_q && in_rng(adr_q);
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      cnt   <= '0;
      we_q  <= 1'b0;
      adr_q <= '0;
      sel_q <= '0;
      dat_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q  <= WE;
        adr_q <= ADR;
        sel_q <= SEL;
        dat_q <= DAT_M;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       DAT_S <= '0;
    else if (load_rd) DAT_S <= mem[rd_idx];
  end

  // Dropping CYC in RESP cancels the commit along with the ACK.
  assign commit = resp_ok & we_q & in_rng(adr_q);

  always_ff @(posedge CLK) begin
    if (commit) begin
      for (int i = 0; i < 16; i++)
        if (sel_q[i]) mem[adr_q[AW-1:0]][8*i +: 8] <= dat_q[8*i +: 8];
    end
  end

  assign STALL = (state != S_IDLE);
  assign ACK   = resp_ok & in_rng(adr_q);
  assign RTY   = resp_ok & !in_rng(adr_q);

endmodule

// File: tb/tb_wb_pmem_responder.sv
// Directed bench: DUT 0 at LATENCY=4/DEPTH=4096, DUT 1 at LATENCY=1/DEPTH=256.
module tb_wb_pmem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]         cyc, stb, we;
  logic [1:0][11:0]   adr;
  logic [1:0][15:0]   sel;
  logic [1:0][127:0]  datm;
  logic               ack_a, ack_b, stall_a, stall_b, rty_a, rty_b;
  logic [127:0]       dats_a, dats_b;
  logic [1:0]         ack, stall, rty;
  logic [1:0][127:0]  dats;

  assign ack   = {ack_b, ack_a};
  assign stall = {stall_b, stall_a};
  assign rty   = {rty_b, rty_a};
  assign dats  = {dats_b, dats_a};

  int total = 0;
  int bad   = 0;

  wb_pmem_responder #(.DEPTH(4096), .LATENCY(4)) dut (
    .CLK(clk), .RST_N(rst_n), .CYC(cyc[0]), .STB(stb[0]), .WE(we[0]),
    .ADR(adr[0]), .SEL(sel[0]), .DAT_M(datm[0]), .DAT_S(dats_a),
    .ACK(ack_a), .STALL(stall_a), .RTY(rty_a));

  wb_pmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .CYC(cyc[1]), .STB(stb[1]), .WE(we[1]),
    .ADR(adr[1]), .SEL(sel[1]), .DAT_M(datm[1]), .DAT_S(dats_b),
    .ACK(ack_b), .STALL(stall_b), .RTY(rty_b));

  localparam logic [127:0] LA = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] LB = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1234_5678;
  localparam logic [127:0] LW = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  // Single transaction from an idle DUT; lat = edges from acceptance to ACK/RTY, -1 on timeout.
  task automatic xfer(input int d, input logic w, input logic [11:0] a, input logic [15:0] s,
                      input logic [127:0] dm, output int lat, output logic [127:0] rd,
                      output logic ak, output logic rt, output int stl);
    lat = -1; rd = '0; ak = 1'b0; rt = 1'b0; stl = 0;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; datm[d] = dm;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      stb[d] = 1'b0;
      if (stall[d]) stl++;
      if (ack[d] || rty[d]) begin
        lat = k; rd = dats[d]; ak = ack[d]; rt = rty[d];
        break;
      end
    end
    @(negedge clk);
    cyc[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic test_reset();
    int lat, stl, seen;
    logic [127:0] rd;
    logic ak, rt;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({ack_a, stall_a, rty_a, dats_a} !== 131'd0) begin bad++; $display("FAIL reset_outs0: got %h want 0", {ack_a, stall_a, rty_a, dats_a}); end
    total++; if ({ack_b, stall_b, rty_b, dats_b} !== 131'd0) begin bad++; $display("FAIL reset_outs1: got %h want 0", {ack_b, stall_b, rty_b, dats_b}); end
    rst_n = 1'b1;
    xfer(0, 1'b1, 12'h010, 16'hFFFF, LA, lat, rd, ak, rt, stl);
    total++; if (lat !== 4) begin bad++; $display("FAIL reset_prewr_lat: got %0d want 4", lat); end
    xfer(0, 1'b0, 12'h010, 16'h0000, '0, lat, rd, ak, rt, stl);
    total++; if (rd !== LA) begin bad++; $display("FAIL reset_prerd: got %h want %h", rd, LA); end
    // write LB to 0x010, then reset while in WAIT
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 12'h010; sel[0] = 16'hFFFF; datm[0] = LB;
    @(posedge clk);
    @(negedge clk); stb[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (stall_a !== 1'b1) begin bad++; $display("FAIL reset_midwait_stall: got %b want 1", stall_a); end
    rst_n = 1'b0;
    #1;
    total++; if ({ack_a, stall_a, rty_a, dats_a} !== 131'd0) begin bad++; $display("FAIL reset_async: got %h want 0", {ack_a, stall_a, rty_a, dats_a}); end
    cyc[0] = 1'b0; we[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (ack_a) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL reset_no_ack: got %0d acks want 0", seen); end
    xfer(0, 1'b0, 12'h010, 16'h0000, '0, lat, rd, ak, rt, stl);
    total++; if (rd !== LA) begin bad++; $display("FAIL reset_discard: got %h want %h", rd, LA); end
  endtask

  task automatic test_write_read();
    int lat, stl;
    logic [127:0] rd;
    logic ak, rt;
    xfer(0, 1'b1, 12'h123, 16'hFFFF, LW, lat, rd, ak, rt, stl);
    total++; if (lat !== 4) begin bad++; $display("FAIL wr_lat: got %0d want 4", lat); end
    total++; if (stl !== 4) begin bad++; $display("FAIL wr_stall_cycles: got %0d want 4", stl); end
    total++; if (rd !== LA) begin bad++; $display("FAIL wr_dats_hold: got %h want %h", rd, LA); end
    xfer(0, 1'b0, 12'h123, 16'h0000, '0, lat, rd, ak, rt, stl);
    total++; if (lat !== 4) begin bad++; $display("FAIL rd_lat: got %0d want 4", lat); end
    total++; if (rd !== LW) begin bad++; $display("FAIL rd_data: got %h want %h", rd, LW); end
    total++; if (rt !== 1'b0) begin bad++; $display("FAIL rd_no_rty: got %b want 0", rt); end
  endtask

  task automatic test_byte_mask();
    int lat, stl;
    logic [127:0] rd, exp;
    logic ak, rt;
    exp = {{14{8'hAA}}, 16'h5555};
    xfer(0, 1'b1, 12'h040, 16'hFFFF, {16{8'hAA}}, lat, rd, ak, rt, stl);
    xfer(0, 1'b1, 12'h040, 16'h0003, {16{8'h55}}, lat, rd, ak, rt, stl);
    xfer(0, 1'b0, 12'h040, 16'h0000, '0, lat, rd, ak, rt, stl);
    total++; if (rd !== exp) begin bad++; $display("FAIL mask_data: got %h want %h", rd, exp); end
    xfer(0, 1'b1, 12'h040, 16'h0000, '0, lat, rd, ak, rt, stl);
    total++; if (lat !== 4 || ak !== 1'b1) begin bad++; $display("FAIL sel0_ack: got lat %0d ack %b want 4 1", lat, ak); end
    xfer(0, 1'b0, 12'h040, 16'h0000, '0, lat, rd, ak, rt, stl);
    total++; if (rd !== exp) begin bad++; $display("FAIL sel0_data: got %h want %h", rd, exp); end
  endtask

  task automatic test_abort();
    int lat, stl, seen;
    logic [127:0] rd;
    logic ak, rt;
    xfer(0, 1'b1, 12'h200, 16'hFFFF, LB, lat, rd, ak, rt, stl);
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 12'h200; sel[0] = 16'hFFFF; datm[0] = {16{8'hFF}};
    @(posedge clk);
    @(negedge clk); stb[0] = 1'b0;
    @(posedge clk);
    @(negedge clk); cyc[0] = 1'b0; we[0] = 1'b0;
    @(negedge clk);
    total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL abort_idle: got stall %b want 0", stall_a); end
    seen = 0;
    repeat (6) begin @(negedge clk); if (ack_a) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_ack: got %0d acks want 0", seen); end
    xfer(0, 1'b0, 12'h200, 16'h0000, '0, lat, rd, ak, rt, stl);
    total++; if (rd !== LB) begin bad++; $display("FAIL abort_data: got %h want %h", rd, LB); end
    // abort while in RESP: ACK drops with CYC and the write is not committed
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 12'h200; sel[0] = 16'hFFFF; datm[0] = LW;
    @(posedge clk);
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); stb[0] = 1'b0;
      if (ack_a) begin seen = k; break; end
    end
    cyc[0] = 1'b0; we[0] = 1'b0;
    #1;
    total++; if (seen !== 4 || ack_a !== 1'b0) begin bad++; $display("FAIL resp_abort_ack: got at %0d now %b want 4 0", seen, ack_a); end
    xfer(0, 1'b0, 12'h200, 16'h0000, '0, lat, rd, ak, rt, stl);
    total++; if (rd !== LB) begin bad++; $display("FAIL resp_abort_data: got %h want %h", rd, LB); end
  endtask

  task automatic test_back_to_back();
    int lat, stl;
    logic [127:0] rd;
    logic ak, rt;
    xfer(1, 1'b1, 12'h005, 16'hFFFF, LA, lat, rd, ak, rt, stl);
    total++; if (lat !== 1 || stl !== 1) begin bad++; $display("FAIL b2b_wr_lat: got %0d/%0d want 1/1", lat, stl); end
    xfer(1, 1'b1, 12'h006, 16'hFFFF, LB, lat, rd, ak, rt, stl);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 12'h005;
    @(posedge clk);
    @(negedge clk);
    total++; if ({ack_b, stall_b} !== 2'b11 || dats_b !== LA) begin bad++; $display("FAIL b2b_first: got ack/stall %b%b data %h want 11 %h", ack_b, stall_b, dats_b, LA); end
    adr[1] = 12'h006;
    @(negedge clk);
    total++; if ({ack_b, stall_b} !== 2'b00) begin bad++; $display("FAIL b2b_gap: got ack/stall %b%b want 00", ack_b, stall_b); end
    @(negedge clk);
    total++; if ({ack_b, stall_b} !== 2'b11 || dats_b !== LB) begin bad++; $display("FAIL b2b_second: got ack/stall %b%b data %h want 11 %h", ack_b, stall_b, dats_b, LB); end
    @(negedge clk);
    total++; if ({ack_b, stall_b} !== 2'b00) begin bad++; $display("FAIL b2b_after: got ack/stall %b%b want 00", ack_b, stall_b); end
    cyc[1] = 1'b0; stb[1] = 1'b0;
  endtask

  task automatic test_range();
    int lat, stl;
    logic [127:0] rd;
    logic ak, rt;
`ifdef WB_PMEM_RANGE_CHECK_EN
    xfer(1, 1'b0, 12'h005, 16'h0000, '0, lat, rd, ak, rt, stl);
    total++; if (rd !== LA) begin bad++; $display("FAIL rng_pre: got %h want %h", rd, LA); end
    xfer(1, 1'b0, 12'h300, 16'h0000, '0, lat, rd, ak, rt, stl);
    total++; if ({lat == 1, ak, rt} !== 3'b101) begin bad++; $display("FAIL rng_rty: got lat %0d ack %b rty %b want 1 0 1", lat, ak, rt); end
    total++; if (rd !== LA) begin bad++; $display("FAIL rng_dats_hold: got %h want %h", rd, LA); end
    @(negedge clk);
    total++; if (rty_b !== 1'b0) begin bad++; $display("FAIL rng_rty_one_cycle: got %b want 0", rty_b); end
`else
    xfer(1, 1'b1, 12'h300, 16'hFFFF, LW, lat, rd, ak, rt, stl);
    total++; if ({ak, rt} !== 2'b10) begin bad++; $display("FAIL wrap_wr: got ack %b rty %b want 1 0", ak, rt); end
    xfer(1, 1'b0, 12'h000, 16'h0000, '0, lat, rd, ak, rt, stl);
    total++; if (rd !== LW) begin bad++; $display("FAIL wrap_rd: got %h want %h", rd, LW); end
    xfer(1, 1'b0, 12'h105, 16'h0000, '0, lat, rd, ak, rt, stl);
    total++; if (rd !== LA) begin bad++; $display("FAIL wrap_rd2: got %h want %h", rd, LA); end
`endif
  endtask

  initial begin
    cyc = '0; stb = '0; we = '0; adr = '0; sel = '0; datm = '0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_abort();
    test_back_to_back();
    test_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
